// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state encoding and the wait-state limit.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_STATES_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational store lane-mask/replication and load extract/extend.
// DMEM_MISALIGN_CHECK_EN: reject misaligned halfword/word accesses.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        misalign;

  assign rbyte = rword[{offset, 3'b000} +: 8];
  assign rhalf = offset[1] ? rword[31:16] : rword[15:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  // funct3[1:0]==01 covers both H and HU
  assign misalign = ((funct3[1:0] == 2'b01) && offset[0]) ||
                    ((funct3 == F3_W) && (offset != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    rdata       = 32'h0;
    err         = 1'b0;
    if (write) begin
      // Replicate narrow data onto every lane; the mask picks the live ones.
      case (funct3)
        F3_B: begin
          byte_en     = 4'b0001 << offset;
          wdata_lanes = {4{wdata[7:0]}};
        end
        F3_H: begin
          byte_en     = offset[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
        end
        F3_W: begin
          byte_en     = 4'b1111;
          wdata_lanes = wdata;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
        F3_BU:   rdata = {24'h0, rbyte};
        F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
        F3_HU:   rdata = {16'h0, rhalf};
        F3_W:    rdata = rword;
        default: err = 1'b1;
      endcase
    end
    if (misalign) begin
      err = 1'b1;
    end
    if (err) begin
      byte_en = 4'b0000;
      rdata   = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES extra cycles,
// one-cycle response pulse. Optional macro: DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
    $error("dmem_responder: WAIT_STATES out of range");
  end

  state_t         state_reg, state_next;
  logic [2:0]     cnt_reg, cnt_next;
  logic           write_reg;
  logic [AW+1:0]  addr_reg;
  logic [31:0]    wdata_reg;
  logic [2:0]     funct3_reg;
  logic           accept;
  logic           access;

  logic [31:0]    ram [DEPTH_WORDS];

  // With zero wait states the access happens on the accepting edge, so the
  // operands come straight from the request bus instead of the latches.
  logic           op_write;
  logic [AW+1:0]  op_addr;
  logic [31:0]    op_wdata;
  logic [2:0]     op_funct3;
  logic [AW-1:0]  op_idx;
  logic [31:0]    rword;
  logic [3:0]     byte_en;
  logic [31:0]    wdata_lanes;
  logic [31:0]    merged_word;
  logic [31:0]    align_rdata;
  logic           align_err;
  logic           unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid && req_ready;

  assign op_write  = (state_reg == IDLE) ? req_write         : write_reg;
  assign op_addr   = (state_reg == IDLE) ? req_addr[AW+1:0]  : addr_reg;
  assign op_wdata  = (state_reg == IDLE) ? req_wdata         : wdata_reg;
  assign op_funct3 = (state_reg == IDLE) ? req_funct3        : funct3_reg;
  assign op_idx    = op_addr[AW+1:2];
  assign rword     = ram[op_idx];

  dmem_lane_align u_align (
    .write       (op_write),
    .offset      (op_addr[1:0]),
    .funct3      (op_funct3),
    .wdata       (op_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (align_rdata),
    .err         (align_err)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[gi*8 +: 8] = byte_en[gi] ? wdata_lanes[gi*8 +: 8]
                                                : rword[gi*8 +: 8];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    access     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = RESP;
          access     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'h0;
      funct3_reg <= 3'd0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg  <= req_write;
        addr_reg   <= req_addr[AW+1:0];
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
      end
      if (access) begin
        rsp_rdata <= align_rdata;
        rsp_err   <= align_err;
      end
    end
  end

  // Contents are never reset; a reset edge simply suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && access && (byte_en != 4'b0000)) begin
      ram[op_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expectations queued at acceptance,
// checked (data, error, latency) when rsp_valid pulses.
module tb_dmem_responder;

  localparam int WS = 1;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   gap_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after acceptance with
  // req_valid still high so consecutive calls form back-to-back traffic.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                       input bit expect_rsp);
    int waits;
    waits      = 0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (gap_check) check_eq("ready_gap", 32'(waits), 32'(WS + 1));
    if (expect_rsp) sb.push_back('{exp_rd, exp_err, cyc + 1});
    $display("[TB] req %s addr=%h wdata=%h f3=%0d", wr ? "ST" : "LD", addr, wd, f3);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("[TB] rsp rdata=%h err=%0d exp_rdata=%h exp_err=%0d", rsp_rdata, rsp_err, e.rdata, e.err);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        check_eq("latency", 32'(cyc - e.acc), 32'(WS));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // Back-to-back stream: valid held high throughout.
    issue(1'b1, 32'h10, 32'hDEADBEEF, W, 32'h0, 1'b0, 1'b1);
    gap_check = 1'b1;
    issue(1'b0, 32'h10, 32'h0, W, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b1, 32'h13, 32'h00000080, B, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h13, 32'h0, B, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, 32'h13, 32'h0, BU, 32'h00000080, 1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, W, 32'h80ADBEEF, 1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 32'h10, 32'h12345678, 3'b100, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 32'h10, 32'h12345678, 3'b011, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h10, 32'h0, W, 32'h80ADBEEF, 1'b0, 1'b1);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue(1'b0, 32'h12, 32'h0, W, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h11, 32'h0, H, 32'h0, 1'b1, 1'b1);
`else
    issue(1'b0, 32'h12, 32'h0, W, 32'h80ADBEEF, 1'b0, 1'b1);
    issue(1'b0, 32'h11, 32'h0, H, 32'hFFFFBEEF, 1'b0, 1'b1);
`endif
    issue(1'b1, 32'h14, 32'h11223344, W, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h16, 32'hFFFF8001, H, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h16, 32'h0, H, 32'hFFFF8001, 1'b0, 1'b1);
    issue(1'b0, 32'h16, 32'h0, HU, 32'h00008001, 1'b0, 1'b1);
    issue(1'b0, 32'h14, 32'h0, H, 32'h00003344, 1'b0, 1'b1);
    issue(1'b0, 32'h15, 32'h0, B, 32'h00000033, 1'b0, 1'b1);
    issue(1'b0, 32'h17, 32'h0, BU, 32'h00000080, 1'b0, 1'b1);
    issue(1'b0, 32'h14, 32'h0, W, 32'h80013344, 1'b0, 1'b1);
    issue(1'b1, 32'h1018, 32'h55AA55AA, W, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h18, 32'h0, W, 32'h55AA55AA, 1'b0, 1'b1);
    req_valid = 1'b0;
    gap_check = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while a store sits in WAIT: the store must vanish.
    issue(1'b1, 32'h20, 32'h11112222, W, 32'h0, 1'b0, 1'b1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b1, 32'h20, 32'h99999999, W, 32'h0, 1'b0, 1'b0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    check_eq("ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst2", 32'(req_ready), 32'd1);
    check_eq("rsp_valid_after_rst2", 32'(rsp_valid), 32'd0);
    issue(1'b0, 32'h20, 32'h0, W, 32'h11112222, 1'b0, 1'b1);
    req_valid = 1'b0;

    repeat (6) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
